// File: rtl/axi4_stream_byte_compact_pkg.sv
// Shared types and helpers for the AXI4-Stream byte compactor.
// Used with or without AXI4_STREAM_BYTE_COMPACT_STAT_EN.
package axi4_stream_compact_pkg;

    typedef enum logic {
        RUN_S,
        FLUSH_S
    } state_t;

    localparam int unsigned MAX_LANES = 128;

    // Low-aligned byte-enable mask with cnt bits set.
    function automatic logic [MAX_LANES-1:0] keep_mask(
        input int unsigned cnt
    );
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (i < cnt) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/axi4_stream_byte_compact_if.sv
// AXI4-Stream bundle with master/slave views.
// Widths follow the instantiating context.
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [KEEP_WIDTH-1:0] tstrb;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tstrb,
        output tlast,
        output tid,
        output tdest,
        output tuser,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tstrb,
        input  tlast,
        input  tid,
        input  tdest,
        input  tuser,
        output tready
    );

endinterface

// File: rtl/axi4_stream_byte_pack.sv
// Combinational lane packer: gathers kept bytes in ascending
// lane order into the low lanes and reports how many there are.
module axi4_stream_byte_pack
    import axi4_stream_compact_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int W          = DATA_WIDTH / 8,
    localparam int CW         = $clog2(W)
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [W-1:0]          keep_i,
    input  logic [W-1:0]          strb_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [W-1:0]          strb_o,
    output logic [CW:0]           cnt_o
);

    always_comb begin
        int unsigned k;
        k      = 0;
        data_o = '0;
        strb_o = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (keep_i[i]) begin
                data_o[k*8 +: 8] = data_i[i*8 +: 8];
                strb_o[k]        = strb_i[i];
                k                = k + 1;
            end
        end
        cnt_o = (CW+1)'(k);
    end

endmodule

// File: rtl/axi4_stream_byte_compact.sv
// Drops null bytes from an AXI4-Stream packet and repacks LSB-aligned.
// Optional counters: define AXI4_STREAM_BYTE_COMPACT_STAT_EN.
module axi4_stream_byte_compact
    import axi4_stream_compact_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    parameter int STAT_WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    axi4_stream_if.slave  pkt_i,
    axi4_stream_if.master pkt_o
`ifdef AXI4_STREAM_BYTE_COMPACT_STAT_EN
    ,
    output logic [STAT_WIDTH-1:0] null_byte_cnt_o,
    output logic [STAT_WIDTH-1:0] pkt_cnt_o
`endif
);

    localparam int         W   = DATA_WIDTH / 8;
    localparam int         CW  = $clog2(W);
    localparam logic [CW:0] W_C = (CW+1)'(W);

    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 16 || STAT_WIDTH <= CW) begin : g_cfg_check
        $error("axi4_stream_byte_compact: unsupported DATA_WIDTH/STAT_WIDTH");
    end

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] p_data;
    logic [W-1:0]          p_strb;
    logic [CW:0]           p_cnt;

    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic [W-1:0]          res_strb_q, res_strb_d;
    logic [CW-1:0]         res_cnt_q, res_cnt_d;

    logic [CW:0]             total;
    logic [2*DATA_WIDTH-1:0] c_data;
    logic [2*W-1:0]          c_strb;

    logic                  o_valid_q;
    logic [DATA_WIDTH-1:0] o_data_q;
    logic [W-1:0]          o_keep_q;
    logic [W-1:0]          o_strb_q;
    logic                  o_last_q;
    logic [ID_WIDTH-1:0]   o_id_q;
    logic [DEST_WIDTH-1:0] o_dest_q;
    logic [USER_WIDTH-1:0] o_user_q;

    logic                  out_free;
    logic                  in_ready;
    logic                  take;
    logic                  emit;
    logic                  load_side;
    logic [DATA_WIDTH-1:0] e_data;
    logic [W-1:0]          e_keep;
    logic [W-1:0]          e_strb;
    logic                  e_last;

    logic last_big;
    logic last_fit;
    logic word_full;
    logic word_part;

    axi4_stream_byte_pack #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pack (
        .data_i (pkt_i.tdata),
        .keep_i (pkt_i.tkeep),
        .strb_i (pkt_i.tstrb),
        .data_o (p_data),
        .strb_o (p_strb),
        .cnt_o  (p_cnt)
    );

    assign out_free = !o_valid_q || pkt_o.tready;
    assign in_ready = (state_q == RUN_S) && out_free;
    assign take     = pkt_i.tvalid && in_ready;

    assign pkt_i.tready = in_ready;

    // Residue sits in the low lanes; the fresh packed bytes go right above it.
    assign total  = {1'b0, res_cnt_q} + p_cnt;
    assign c_data = {{DATA_WIDTH{1'b0}}, res_data_q}
                  | ({{DATA_WIDTH{1'b0}}, p_data} << {res_cnt_q, 3'b000});
    assign c_strb = {{W{1'b0}}, res_strb_q}
                  | ({{W{1'b0}}, p_strb} << res_cnt_q);

    assign last_big  =  pkt_i.tlast && (total >  W_C);
    assign last_fit  =  pkt_i.tlast && (total <= W_C);
    assign word_full = !pkt_i.tlast && (total >= W_C);
    assign word_part = !pkt_i.tlast && (total <  W_C);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN_S;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN_S: begin
                if (take && last_big) begin
                    state_d = FLUSH_S;
                end
            end
            FLUSH_S: begin
                if (out_free) begin
                    state_d = RUN_S;
                end
            end
            default: state_d = RUN_S;
        endcase
    end

    always_comb begin
        emit       = 1'b0;
        load_side  = 1'b0;
        e_data     = c_data[DATA_WIDTH-1:0];
        e_strb     = c_strb[W-1:0];
        e_keep     = '1;
        e_last     = 1'b0;
        res_data_d = res_data_q;
        res_strb_d = res_strb_q;
        res_cnt_d  = res_cnt_q;
        unique case (state_q)
            RUN_S: begin
                if (take) begin
                    unique case (1'b1)
                        last_big, word_full: begin
                            emit       = 1'b1;
                            load_side  = 1'b1;
                            res_data_d = c_data[2*DATA_WIDTH-1:DATA_WIDTH];
                            res_strb_d = c_strb[2*W-1:W];
                            res_cnt_d  = CW'(total - W_C);
                        end
                        last_fit: begin
                            emit       = 1'b1;
                            load_side  = 1'b1;
                            e_keep     = W'(keep_mask(32'(total)));
                            e_last     = 1'b1;
                            res_data_d = '0;
                            res_strb_d = '0;
                            res_cnt_d  = '0;
                        end
                        word_part: begin
                            res_data_d = c_data[DATA_WIDTH-1:0];
                            res_strb_d = c_strb[W-1:0];
                            res_cnt_d  = CW'(total);
                        end
                        default: ;
                    endcase
                end
            end
            FLUSH_S: begin
                if (out_free) begin
                    emit       = 1'b1;
                    e_data     = res_data_q;
                    e_strb     = res_strb_q;
                    e_keep     = W'(keep_mask(32'(res_cnt_q)));
                    e_last     = 1'b1;
                    res_data_d = '0;
                    res_strb_d = '0;
                    res_cnt_d  = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_data_q <= '0;
            res_strb_q <= '0;
            res_cnt_q  <= '0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_keep_q   <= '0;
            o_strb_q   <= '0;
            o_last_q   <= 1'b0;
            o_id_q     <= '0;
            o_dest_q   <= '0;
            o_user_q   <= '0;
        end else begin
            res_data_q <= res_data_d;
            res_strb_q <= res_strb_d;
            res_cnt_q  <= res_cnt_d;
            if (emit) begin
                o_valid_q <= 1'b1;
                o_data_q  <= e_data;
                o_keep_q  <= e_keep;
                o_strb_q  <= e_strb;
                o_last_q  <= e_last;
                // A flush word keeps the sideband of the tlast beat.
                if (load_side) begin
                    o_id_q   <= pkt_i.tid;
                    o_dest_q <= pkt_i.tdest;
                    o_user_q <= pkt_i.tuser;
                end
            end else if (pkt_o.tready) begin
                o_valid_q <= 1'b0;
            end
        end
    end

    assign pkt_o.tvalid = o_valid_q;
    assign pkt_o.tdata  = o_data_q;
    assign pkt_o.tkeep  = o_keep_q;
    assign pkt_o.tstrb  = o_strb_q;
    assign pkt_o.tlast  = o_last_q;
    assign pkt_o.tid    = o_id_q;
    assign pkt_o.tdest  = o_dest_q;
    assign pkt_o.tuser  = o_user_q;

`ifdef AXI4_STREAM_BYTE_COMPACT_STAT_EN
    logic [CW:0]         null_n;
    logic [STAT_WIDTH:0] null_sum;
    logic [STAT_WIDTH-1:0] null_cnt_q;
    logic [STAT_WIDTH-1:0] pkt_cnt_q;

    assign null_n   = W_C - p_cnt;
    assign null_sum = {1'b0, null_cnt_q} + (STAT_WIDTH+1)'(null_n);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            null_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            if (take) begin
                null_cnt_q <= null_sum[STAT_WIDTH] ? '1
                                                   : null_sum[STAT_WIDTH-1:0];
            end
            if (o_valid_q && pkt_o.tready && o_last_q && (pkt_cnt_q != '1)) begin
                pkt_cnt_q <= pkt_cnt_q + 1'b1;
            end
        end
    end

    assign null_byte_cnt_o = null_cnt_q;
    assign pkt_cnt_o       = pkt_cnt_q;
`endif

endmodule

// File: doc/axi4_stream_byte_compact.md
Name: axi4_stream_byte_compact

Overview:
- Upstream conditioning stage for the packet fragmenter.
- Removes null bytes (tkeep=0) from an AXI4-Stream packet and repacks the remaining bytes contiguously, LSB-aligned. Every output word except the last of each packet is full; the last word carries valid bytes in its low lanes only.
- This guarantees the contiguous-byte stream that the fragmenter's byte counting and shifting require.

Parameters:
- DATA_WIDTH, 32, tdata width in bits; multiple of 8, at least 16.
- ID_WIDTH, 1, tid width.
- DEST_WIDTH, 1, tdest width.
- USER_WIDTH, 1, tuser width.
- STAT_WIDTH, 32, width of statistics counters (optional feature only).

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  reset, synchronous, active-high.
- pkt_i  axi4_stream_if slave  DATA_WIDTH  input stream with sparse tkeep.
- pkt_o  axi4_stream_if master  DATA_WIDTH  compacted output stream.
- null_byte_cnt_o  out  STAT_WIDTH  present only with the optional feature.
- pkt_cnt_o  out  STAT_WIDTH  present only with the optional feature.

Behaviour:
- Constants: W = DATA_WIDTH/8, CW = $clog2(W).
- Valid byte: tkeep[i]=1. The tstrb bit of each valid byte travels with that byte (position bytes are preserved). A byte with tkeep=0 is dropped regardless of tstrb.
- Per accepted beat, a combinational prefix sum packs the n valid bytes (0..W) in ascending lane order into vector P.
- Residue register holds res_cnt bytes (0..W-1), LSB-aligned, plus their tstrb.
- Concatenation C = residue (low) followed by P; total = res_cnt + n, width CW+1 bits, maximum 2W-1.
- Output register stage: o_valid, o_data, o_keep, o_strb, o_last, o_id, o_dest, o_user.
- pkt_i.tready = (state==RUN) && (!o_valid || pkt_o.tready).
- On an accepted beat, RUN state:
  - total>=W, no tlast: load o_* with C[W-1:0], o_keep all ones, o_last=0; residue <= C upper bytes; res_cnt <= total-W.
  - total<W, no tlast: residue <= C; nothing emitted.
  - tlast, total<=W: emit C with o_keep = low total bits set, o_last=1; res_cnt <= 0.
  - tlast, total>W: emit first W bytes with o_last=0; residue <= remainder; go to FLUSH.
  - tlast, total=0: emit one beat with tkeep='0, tstrb='0, tlast=1, so the packet boundary is never lost.
- FLUSH state: pkt_i.tready=0. When the output register is free, emit the residue with o_keep = low res_cnt bits and o_last=1; then res_cnt <= 0 and go to RUN.
- Latency: 1 cycle from the accepting clock edge to pkt_o.tvalid. Full throughput except one extra bubble per packet whose tail overflows a word.
- o_id, o_dest, o_user: taken from the most recently accepted input beat contributing to the word. In FLUSH they hold the tlast beat's values.
- Backpressure: o_* are stable while o_valid && !pkt_o.tready. The residue updates only on input acceptance.
- Reset (synchronous): state=RUN, res_cnt=0, o_valid=0, all o_* =0; pkt_o.tvalid=0, pkt_o.tlast=0, tkeep=0, tstrb=0, tdata=0. Reset mid-packet discards the residue and any partial packet, with no flush.
- Input with tvalid=1, tkeep=0 and tlast=0 is accepted and consumed silently.

Optional Feature:
- Macro AXI4_STREAM_BYTE_COMPACT_STAT_EN.
- Defined: null_byte_cnt_o adds (W - n) per accepted beat; pkt_cnt_o increments on each output beat with tlast. Both saturate at all-ones and reset to 0.
- Undefined: both ports and all counter logic are absent.

Decomposition:
- Package axi4_stream_compact_pkg: state enum {RUN_S, FLUSH_S}, and a function returning a low-aligned keep mask from a count.
- Sub-module axi4_stream_byte_pack: purely combinational. Inputs tdata/tkeep/tstrb; outputs packed data, packed strobe and count n. Instantiated once.

Test Plan (DATA_WIDTH=32):
- Dense packet of 3 beats, tkeep=F each, last beat tkeep=3 -> output identical, tlast on beat 3, tkeep=3, latency 1 cycle.
- Beats tkeep=5 (data AA,–,CC,–), then tkeep=A (–,DD,–,EE) with tlast -> one beat: data EE_DD_CC_AA, tkeep=F, tlast=1.
- Beats tkeep=7, then tkeep=F with tlast -> beat 1 tkeep=F tlast=0; FLUSH beat tkeep=7 tlast=1; pkt_i.tready low for exactly 1 cycle.
- Single beat tkeep=0 with tlast -> one output beat, tkeep=0, tlast=1.
- Random pkt_o.tready at 50% duty over 200 random sparse packets -> output byte sequence equals input valid bytes; no gaps inside packets; tstrb preserved per byte.
- Assert rst_i mid-packet with residue=3 -> next cycle pkt_o.tvalid=0; the following packet comes out uncontaminated. With STAT_EN: counters read 0 after reset, null_byte_cnt_o matches the scoreboard.
